luzes_sequenciais: RTL and testbench

//  Parametrised LED sequencer for the board's LED bank.
//  - Divides clock_placa into a one-cycle step tick.
//  - On each tick, advances an N-bit LED pattern in one of four modes:

---
 rtl/luzes_pkg.sv | 14 +
 rtl/luzes_sequenciais_divisor_tick.sv | 42 ++++
 rtl/luzes_sequenciais.sv | 77 +++++++
 tb/tb_luzes_sequenciais.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/luzes_pkg.sv
// Shared encodings for the LED sequencer: step modes and bounce direction.
package luzes_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SHR_IN = 2'b00;
    localparam mode_t MODE_SHL_IN = 2'b01;
    localparam mode_t MODE_ROTATE = 2'b10;
    localparam mode_t MODE_BOUNCE = 2'b11;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/luzes_sequenciais_divisor_tick.sv
// Clock-enable generator: one-cycle registered tick every DIV cycles of clock_placa.
module divisor_tick #(
    parameter int unsigned DIV = 50000000
) (
    input  logic clock_placa,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          tick_next;

    // Counter wraps after LAST; tick is raised for the cycle following the wrap.
    always_comb begin
        cnt_next  = cnt;
        tick_next = 1'b0;
        if (enable) begin
            if (cnt == LAST) begin
                cnt_next  = '0;
                tick_next = 1'b1;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clock_placa or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            tick <= tick_next;
        end
    end

endmodule

// File: rtl/luzes_sequenciais.sv
// LED sequencer: advances an N-bit pattern once per divider tick in one of four modes.
module luzes_sequenciais
    import luzes_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned DIV        = 50000000,
    parameter logic [N-1:0] PRESET_VAL = {N{1'b1}}
) (
    input  logic         clock_placa,
    input  logic         reset,
    input  logic         preset,
    input  logic         enable,
    input  logic [1:0]   mode,
    input  logic         in,
    output logic [N-1:0] leds,
    output logic         tick,
    output logic         dir
);

    localparam logic [N-1:0] SEED = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0] leds_next;
    logic         dir_next;

    divisor_tick #(
        .DIV(DIV)
    ) u_divisor_tick (
        .clock_placa(clock_placa),
        .reset      (reset),
        .enable     (enable),
        .tick       (tick)
    );

    // Preset overrides a coincident step; otherwise the pattern moves only on tick.
    always_comb begin
        leds_next = leds;
        dir_next  = dir;
        if (preset) begin
            leds_next = PRESET_VAL;
            dir_next  = DIR_RIGHT;
        end else if (tick) begin
            case (mode)
                MODE_SHR_IN: leds_next = {in, leds[N-1:1]};
                MODE_SHL_IN: leds_next = {leds[N-2:0], in};
                MODE_ROTATE: leds_next = {leds[0], leds[N-1:1]};
                MODE_BOUNCE: begin
                    if (leds == '0) begin
                        leds_next = SEED;
                        dir_next  = DIR_RIGHT;
                    end else if (dir == DIR_RIGHT && leds[0]) begin
                        leds_next = {leds[N-2:0], 1'b0};
                        dir_next  = DIR_LEFT;
                    end else if (dir == DIR_LEFT && leds[N-1]) begin
                        leds_next = {1'b0, leds[N-1:1]};
                        dir_next  = DIR_RIGHT;
                    end else if (dir == DIR_RIGHT) begin
                        leds_next = {1'b0, leds[N-1:1]};
                    end else begin
                        leds_next = {leds[N-2:0], 1'b0};
                    end
                end
                default: leds_next = leds;
            endcase
        end
    end

    always_ff @(posedge clock_placa or posedge reset) begin
        if (reset) begin
            leds <= '0;
            dir  <= DIR_RIGHT;
        end else begin
            leds <= leds_next;
            dir  <= dir_next;
        end
    end

endmodule

// File: tb/tb_luzes_sequenciais.sv
// Directed bench for luzes_sequenciais: N=4/DIV=4 instance plus an N=8/DIV=2 instance.
module tb_luzes_sequenciais;

    localparam int unsigned DIV_A = 4;

    logic       clock_placa;
    logic       reset;
    logic       preset;
    logic       enable;
    logic [1:0] mode;
    logic       in;
    logic [3:0] leds;
    logic       tick;
    logic       dir;

    logic       reset8;
    logic       in8;
    logic [7:0] leds8;
    logic       tick8;
    logic       dir8;

    int n_checks = 0;
    int n_fails  = 0;

    luzes_sequenciais #(.N(4), .DIV(DIV_A)) u_dut (
        .clock_placa(clock_placa),
        .reset      (reset),
        .preset     (preset),
        .enable     (enable),
        .mode       (mode),
        .in         (in),
        .leds       (leds),
        .tick       (tick),
        .dir        (dir)
    );

    luzes_sequenciais #(.N(8), .DIV(2)) u_dut8 (
        .clock_placa(clock_placa),
        .reset      (reset8),
        .preset     (1'b0),
        .enable     (1'b1),
        .mode       (2'b00),
        .in         (in8),
        .leds       (leds8),
        .tick       (tick8),
        .dir        (dir8)
    );

    initial clock_placa = 1'b0;
    always #5 clock_placa = ~clock_placa;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a tick seen at a negedge, then let the step edge pass.
    task automatic step();
        for (int k = 0; k < 2 * DIV_A + 2; k++) begin
            if (tick) break;
            @(negedge clock_placa);
        end
        check("step_tick", 32'(tick), 1);
        @(negedge clock_placa);
    endtask

    logic [3:0] bounce_leds [8] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                    4'b0010, 4'b0100, 4'b1000, 4'b0100};
    logic       bounce_dir  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       shr_bits    [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] shr_leds    [4] = '{4'b1010, 4'b0101, 4'b0010, 4'b1001};
    logic [3:0] rot_leds    [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
    logic       stream8     [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] leds8_exp   [8] = '{8'b10000000, 8'b01000000, 8'b10100000, 8'b01010000,
                                    8'b10101000, 8'b01010100, 8'b10101010, 8'b01010101};

    initial begin
        logic tick_at_preset;
        reset  = 1'b1;
        reset8 = 1'b1;
        preset = 1'b0;
        enable = 1'b1;
        mode   = 2'b00;
        in     = 1'b1;
        in8    = 1'b0;
        repeat (2) @(negedge clock_placa);
        check("reset_leds", 32'(leds), 'b0000);
        check("reset_tick", 32'(tick), 0);
        check("reset_dir",  32'(dir),  0);

        // 1: SHR_IN with in=1; first tick DIV cycles after release
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_placa);
            check("first_tick_early", 32'(tick), 0);
        end
        @(negedge clock_placa);
        check("first_tick", 32'(tick), 1);
        @(negedge clock_placa);
        check("shr_in_1", 32'(leds), 'b1000);
        step(); check("shr_in_2", 32'(leds), 'b1100);
        step(); check("shr_in_3", 32'(leds), 'b1110);
        step(); check("shr_in_4", 32'(leds), 'b1111);

        // 2: preset then SHL_IN with in=0
        preset = 1'b1;
        mode   = 2'b01;
        in     = 1'b0;
        @(negedge clock_placa);
        preset = 1'b0;
        check("preset_leds", 32'(leds), 'b1111);
        check("preset_dir",  32'(dir),  0);
        step(); check("shl_in_1", 32'(leds), 'b1110);
        step(); check("shl_in_2", 32'(leds), 'b1100);
        step(); check("shl_in_3", 32'(leds), 'b1000);
        step(); check("shl_in_4", 32'(leds), 'b0000);

        // 3: BOUNCE from an all-zero pattern
        mode = 2'b11;
        for (int i = 0; i < 8; i++) begin
            step();
            check("bounce_leds", 32'(leds), 32'(bounce_leds[i]));
            check("bounce_dir",  32'(dir),  32'(bounce_dir[i]));
        end

        // 4: build 1001 with SHR_IN, rotate, then freeze
        mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            in = shr_bits[i];
            step();
            check("shr_build", 32'(leds), 32'(shr_leds[i]));
        end
        check("dir_kept_outside_bounce", 32'(dir), 0);
        mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rotate", 32'(leds), 32'(rot_leds[i]));
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock_placa);
            check("frozen_leds", 32'(leds), 'b1001);
            check("frozen_tick", 32'(tick), 0);
        end

        // 5: preset on the same edge as a rotate step, then reset mid-count
        enable = 1'b1;
        for (int k = 0; k < 2 * DIV_A + 2; k++) begin
            if (tick) break;
            @(negedge clock_placa);
        end
        tick_at_preset = tick;
        check("tick_with_preset", 32'(tick_at_preset), 1);
        preset = 1'b1;
        @(negedge clock_placa);
        preset = 1'b0;
        check("preset_wins_leds", 32'(leds), 'b1111);
        check("preset_wins_dir",  32'(dir),  0);
        @(negedge clock_placa);
        reset = 1'b1;
        #1;
        check("async_reset_leds", 32'(leds), 'b0000);
        check("async_reset_tick", 32'(tick), 0);
        @(negedge clock_placa);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_placa);
            check("retick_early", 32'(tick), 0);
        end
        @(negedge clock_placa);
        check("retick", 32'(tick), 1);
        @(negedge clock_placa);
        check("rotate_zero_stays", 32'(leds), 'b0000);

        // 6: N=8, DIV=2 SHR_IN following an alternating serial stream
        reset8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock_placa);
            check("div2_tick_low", 32'(tick8), 0);
            if (i > 0) check("div2_leds", 32'(leds8), 32'(leds8_exp[i-1]));
            @(negedge clock_placa);
            check("div2_tick_high", 32'(tick8), 1);
            in8 = stream8[i];
        end
        @(negedge clock_placa);
        check("div2_leds_final", 32'(leds8), 32'(leds8_exp[7]));
        check("div2_dir", 32'(dir8), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
